master_axi_write_sequencer: RTL
===============================

MASTER_AXI_WRITE_SEQUENCER -- requirements
Module: master_axi_write_sequencer

Interface
REQ-001 The module SHALL accept parameter ADDR_WIDTH, default 32, the write address width.
REQ-002 The module SHALL accept parameter DATA_WIDTH, default 32, the write data width.
REQ-003 The module SHALL accept parameter BRESP_WIDTH, default 2, the AXI4 write response width, fixed by spec and not altered at instantiation.
REQ-004 The module SHALL accept parameter TIMEOUT_CYCLES, default 256, the per-phase cycle limit; 0 disables timeout.
REQ-005 The module SHALL have these ports:
- clock  in  1  single clock, all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  system write request valid.
- cmd_ready  out  1  request accepted.
- cmd_addr  in  ADDR_WIDTH  write address.
- cmd_data  in  DATA_WIDTH  write data.
- aw_enable  out  1  enables write address channel.
- aw_done  in  1  address channel transaction complete.
- aw_addr  out  ADDR_WIDTH  registered address.
- w_enable  out  1  enables write data channel.
- w_done  in  1  data channel transaction complete.
- w_data  out  DATA_WIDTH  registered data.
- b_enable  out  1  enables write response channel.
- b_done  in  1  response read out (one-cycle pulse).
- b_response  in  BRESP_WIDTH  response word, valid while b_done=1.
- result_valid  out  1  result available.
- result_ready  in  1  system consumes result.
- result_response  out  BRESP_WIDTH  captured BRESP.
- result_timeout  out  1  transaction aborted by timeout.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 The FSM SHALL have states IDLE, ADDR_DATA, RESPONSE, REPORT.
REQ-007 In IDLE, cmd_ready SHALL be 1. On cmd_valid=1, the block SHALL register cmd_addr/cmd_data into aw_addr/w_data and go to ADDR_DATA on the next edge.
REQ-008 In ADDR_DATA, aw_enable SHALL be 1 until aw_done has been seen, and w_enable SHALL be 1 until w_done has been seen.
- Each done SHALL be latched into a sticky flag.
- The two enables SHALL deassert independently, on the cycle after their own done.
REQ-009 The block SHALL leave ADDR_DATA for RESPONSE on the edge where both flags are set, counting a done arriving on that same cycle. Simultaneous aw_done and w_done SHALL take exactly one cycle.
REQ-010 In RESPONSE, b_enable SHALL be 1. On b_done=1, the block SHALL capture b_response into result_response, clear result_timeout, and go to REPORT.
REQ-011 In REPORT, result_valid SHALL be 1 and all enables SHALL be 0. When result_ready=1, the block SHALL return to IDLE; result_response/result_timeout SHALL hold until the next capture.
REQ-012 aw_addr and w_data SHALL remain stable from acceptance until the transaction returns to IDLE.
REQ-013 A timeout counter SHALL clear on entry to ADDR_DATA and RESPONSE, and increment each cycle in those states.
- If it reaches TIMEOUT_CYCLES (nonzero) before the exit condition, the block SHALL deassert all enables, set result_timeout=1, result_response=0, and go to REPORT.
- A done arriving on the expiry cycle SHALL take priority over the timeout.
REQ-014 The counter SHALL be sized clog2(TIMEOUT_CYCLES+1) bits, minimum 1, and SHALL saturate rather than wrap.
REQ-015 Minimum latency, accept edge to result_valid, SHALL be 3 cycles when aw_done, w_done and b_done each arrive on the first enabled cycle.
REQ-016 Done inputs arriving in states other than their own phase SHALL be ignored.

Reset
REQ-017 While reset_n=0 (asynchronous assertion), the block SHALL force:
- state=IDLE; cmd_ready=0 during reset, 1 after;
- aw_enable=w_enable=b_enable=0, result_valid=0, busy=0;
- aw_addr=0, w_data=0, result_response=0, result_timeout=0, done flags and counter=0.
REQ-018 Reset asserted mid-transaction SHALL abort it with no result reported; deassertion SHALL be synchronised externally.

Verification
REQ-019 Accept addr 0x1000/data 0xA5A5A5A5, all dones on the first enabled cycle, b_response=2'b00 -> result_valid on edge 3, result_response=0, result_timeout=0.
REQ-020 w_done 5 cycles before aw_done -> w_enable drops the cycle after w_done, aw_enable stays high, RESPONSE is entered once after aw_done.
REQ-021 TIMEOUT_CYCLES=8, aw_done never arrives -> enables drop after 8 cycles, result_timeout=1, result_response=0.
REQ-022 b_response=2'b10, result_ready held low 10 cycles -> result_valid and 2'b10 held stable; IDLE one cycle after result_ready=1.
REQ-023 reset_n pulsed low during RESPONSE -> all outputs reach reset values immediately, no result_valid, the next command is processed normally.
REQ-024 TIMEOUT_CYCLES=0 with aw_done delayed 1000 cycles -> no timeout, normal completion.

Source files
------------

// File: rtl/master_axi_write_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | master_axi_write_sequencer_if: command, AXI phase and result signals     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface master_axi_write_sequencer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BRESP_WIDTH = 2
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_data;
  logic                   aw_enable;
  logic                   aw_done;
  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic                   w_enable;
  logic                   w_done;
  logic [DATA_WIDTH-1:0]  w_data;
  logic                   b_enable;
  logic                   b_done;
  logic [BRESP_WIDTH-1:0] b_response;
  logic                   result_valid;
  logic                   result_ready;
  logic [BRESP_WIDTH-1:0] result_response;
  logic                   result_timeout;
  logic                   busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, aw_done, w_done, b_done, b_response, result_ready,
    output cmd_ready, aw_enable, aw_addr, w_enable, w_data, b_enable,
           result_valid, result_response, result_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, aw_done, w_done, b_done, b_response, result_ready,
    input  cmd_ready, aw_enable, aw_addr, w_enable, w_data, b_enable,
           result_valid, result_response, result_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/master_axi_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | master_axi_write_sequencer: one AXI write (AW+W, then B) with timeout    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module master_axi_write_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BRESP_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic                    clock,
  input  wire logic                    reset_n,
  master_axi_write_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_DATA = 2'd1,
    S_RESPONSE  = 2'd2,
    S_REPORT    = 2'd3
  } state_t;

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry fires on the TIMEOUT_CYCLES-th cycle spent in a phase (count starts at 0).
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(TIMEOUT_CYCLES);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_ready_en;
  logic                   r_aw_flag;
  logic                   r_w_flag;
  logic [c_cnt_w-1:0]     r_count;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [BRESP_WIDTH-1:0] r_resp;
  logic                   r_timeout;

  logic w_accept;
  logic w_expire;
  logic w_aw_seen;
  logic w_w_seen;
  logic w_capture;
  logic w_timeout_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_accept         = 1'b0;
    w_capture        = 1'b0;
    w_timeout_fire   = 1'b0;
    w_expire         = (TIMEOUT_CYCLES != 0) && (r_count == c_limit);
    w_aw_seen        = r_aw_flag | bus.aw_done;
    w_w_seen         = r_w_flag | bus.w_done;
    bus.cmd_ready    = 1'b0;
    bus.aw_enable    = 1'b0;
    bus.w_enable     = 1'b0;
    bus.b_enable     = 1'b0;
    bus.result_valid = 1'b0;
    bus.busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = r_ready_en;
        if (r_ready_en && bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ADDR_DATA;
        end
      end
      S_ADDR_DATA: begin
        bus.aw_enable = !r_aw_flag;
        bus.w_enable  = !r_w_flag;
        // A done completing the pair on the expiry cycle wins over the timeout.
        if (w_aw_seen && w_w_seen) begin
          w_state_next = S_RESPONSE;
        end else if (w_expire) begin
          w_timeout_fire = 1'b1;
          w_state_next   = S_REPORT;
        end
      end
      S_RESPONSE: begin
        bus.b_enable = 1'b1;
        if (bus.b_done) begin
          w_capture    = 1'b1;
          w_state_next = S_REPORT;
        end else if (w_expire) begin
          w_timeout_fire = 1'b1;
          w_state_next   = S_REPORT;
        end
      end
      S_REPORT: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_en <= 1'b0;
      r_aw_flag  <= 1'b0;
      r_w_flag   <= 1'b0;
      r_count    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_addr    <= bus.cmd_addr;
        r_data    <= bus.cmd_data;
        r_aw_flag <= 1'b0;
        r_w_flag  <= 1'b0;
      end
      if (r_state == S_ADDR_DATA) begin
        if (bus.aw_done) r_aw_flag <= 1'b1;
        if (bus.w_done)  r_w_flag  <= 1'b1;
      end
      // Any state change restarts the count, so each timed phase starts at zero.
      if (w_state_next != r_state) begin
        r_count <= '0;
      end else if (((r_state == S_ADDR_DATA) || (r_state == S_RESPONSE)) && (r_count != c_max)) begin
        r_count <= r_count + 1'b1;
      end
      if (w_capture) begin
        r_resp    <= bus.b_response;
        r_timeout <= 1'b0;
      end else if (w_timeout_fire) begin
        r_resp    <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.aw_addr         = r_addr;
  assign bus.w_data          = r_data;
  assign bus.result_response = r_resp;
  assign bus.result_timeout  = r_timeout;

endmodule
`default_nettype wire
